// File: rtl/mac_axis_pkt_gen_if.sv
// Shared widths and the AXI-Stream beat bundle between the packet generator
// and its downstream MAC transmit port.
package mac_axis_pkt_gen_pkg;
  localparam int N_SYMBOLS = 8;
  localparam int W_SYMBOL  = 8;
endpackage

interface mac_axis_pkt_gen_if;
  logic                                                                  tvalid;
  logic                                                                  tready;
  logic                                                                  tlast;
  logic [mac_axis_pkt_gen_pkg::N_SYMBOLS-1:0]                            tkeep;
  logic [mac_axis_pkt_gen_pkg::N_SYMBOLS*mac_axis_pkt_gen_pkg::W_SYMBOL-1:0] tdata;

  modport master (output tvalid, tlast, tkeep, tdata, input tready);
  modport slave  (input tvalid, tlast, tkeep, tdata, output tready);
endinterface

// File: rtl/mac_axis_pkt_gen.sv
// Ethernet test-frame generator: streams runs of fixed-length frames with a
// fixed header and an incrementing payload, separated by programmable gaps.
module mac_axis_pkt_gen #(
  parameter logic [47:0] DST_MAC   = 48'hFFFF_FFFF_FFFF,
  parameter logic [47:0] SRC_MAC   = 48'h0200_0000_0001,
  parameter logic [15:0] ETHERTYPE = 16'h88B5
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_clk_en,
  input  logic                  i_start,
  input  logic                  i_stop,
  input  logic [15:0]           i_len,
  input  logic [15:0]           i_n_frames,
  input  logic [7:0]            i_gap,
  mac_axis_pkt_gen_if.master    m_axis,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [31:0]           o_frame_cnt
);
  import mac_axis_pkt_gen_pkg::*;

  localparam int W_BEAT = N_SYMBOLS * W_SYMBOL;
  // Header padded to 16 bytes so the variable byte select never leaves the vector.
  localparam logic [127:0] HDR = {DST_MAC, SRC_MAC, ETHERTYPE, 16'h0000};

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

  state_t       r_state, w_state_next;
  logic [10:0]  r_len, r_off;
  logic [7:0]   r_gap, r_gap_cnt, r_beat, r_last_beat, r_seq;
  logic [15:0]  r_n, r_run_cnt;
  logic         r_stop_pend, r_done;
  logic [31:0]  r_frame_cnt;

  logic [10:0]  w_len_clamp;
  logic [7:0]   w_nbeats;
  logic         w_tvalid, w_is_last, w_accept, w_frame_end, w_end_run, w_finish;
  logic [15:0]  w_run_cnt_inc;
  logic [7:0]   w_last_keep;
  logic [W_BEAT-1:0] w_tdata;

  assign w_len_clamp = (i_len < 16'd60)   ? 11'd60   :
                       (i_len > 16'd1514) ? 11'd1514 : i_len[10:0];
  assign w_nbeats    = w_len_clamp[10:3] + {7'd0, |w_len_clamp[2:0]};

  assign w_tvalid      = (r_state == S_SEND);
  assign w_is_last     = (r_beat == r_last_beat);
  assign w_accept      = i_clk_en & w_tvalid & m_axis.tready;
  assign w_frame_end   = w_accept & w_is_last;
  assign w_run_cnt_inc = r_run_cnt + 16'd1;
  // A stop arriving together with the final beat ends the run at once.
  assign w_end_run     = r_stop_pend | i_stop | ((r_n != 16'd0) && (w_run_cnt_inc == r_n));

  always_comb begin
    w_state_next = r_state;
    w_finish     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_clk_en && i_start && !i_stop)
          w_state_next = S_SEND;
      end
      S_SEND: begin
        if (w_frame_end) begin
          if (w_end_run) begin
            w_state_next = S_IDLE;
            w_finish     = 1'b1;
          end else if (r_gap != 8'd0) begin
            w_state_next = S_GAP;
          end
        end
      end
      S_GAP: begin
        if (i_clk_en) begin
          if (i_stop) begin
            w_state_next = S_IDLE;
            w_finish     = 1'b1;
          end else if (r_gap_cnt == r_gap - 8'd1) begin
            w_state_next = S_SEND;
          end
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)
      r_state <= S_IDLE;
    else
      r_state <= w_state_next;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_len       <= 11'd0;
      r_off       <= 11'd0;
      r_gap       <= 8'd0;
      r_gap_cnt   <= 8'd0;
      r_beat      <= 8'd0;
      r_last_beat <= 8'd0;
      r_seq       <= 8'd0;
      r_n         <= 16'd0;
      r_run_cnt   <= 16'd0;
      r_stop_pend <= 1'b0;
      r_done      <= 1'b0;
      r_frame_cnt <= 32'd0;
    end else if (i_clk_en) begin
      r_done <= w_finish;
      case (r_state)
        S_IDLE: begin
          if (i_start && !i_stop) begin
            r_len       <= w_len_clamp;
            r_last_beat <= w_nbeats - 8'd1;
            r_gap       <= i_gap;
            r_n         <= i_n_frames;
            r_seq       <= 8'd0;
            r_run_cnt   <= 16'd0;
            r_stop_pend <= 1'b0;
            r_beat      <= 8'd0;
            r_off       <= 11'd0;
            r_gap_cnt   <= 8'd0;
          end
        end
        S_SEND: begin
          if (i_stop)
            r_stop_pend <= 1'b1;
          if (w_accept) begin
            if (w_is_last) begin
              r_beat      <= 8'd0;
              r_off       <= 11'd0;
              r_gap_cnt   <= 8'd0;
              r_seq       <= r_seq + 8'd1;
              r_run_cnt   <= w_run_cnt_inc;
              r_frame_cnt <= r_frame_cnt + 32'd1;
            end else begin
              r_beat <= r_beat + 8'd1;
              r_off  <= r_off + 11'd8;
            end
          end
        end
        S_GAP:   r_gap_cnt <= r_gap_cnt + 8'd1;
        default: ;
      endcase
    end
  end

  // Each lane derives its byte from its absolute offset within the frame.
  generate
    for (genvar gi = 0; gi < N_SYMBOLS; gi++) begin : g_sym
      logic [10:0] w_k;
      logic [3:0]  w_hidx;
      logic [7:0]  w_hdr_b, w_pay_b;
      assign w_k     = r_off + 11'(gi);
      assign w_hidx  = 4'd15 - w_k[3:0];
      assign w_hdr_b = HDR[{w_hidx, 3'b000} +: 8];
      assign w_pay_b = w_k[7:0] - 8'd14 + r_seq;
      assign w_tdata[gi*W_SYMBOL +: W_SYMBOL] =
          (!w_tvalid || (w_k >= r_len)) ? 8'h00 :
          (w_k < 11'd14)                ? w_hdr_b : w_pay_b;
    end
  endgenerate

  assign w_last_keep = (r_len[2:0] == 3'd0) ? 8'hFF : ((8'h01 << r_len[2:0]) - 8'h01);

  assign m_axis.tvalid = w_tvalid;
  assign m_axis.tdata  = w_tdata;
  assign m_axis.tlast  = w_tvalid & w_is_last;
  assign m_axis.tkeep  = !w_tvalid ? 8'h00 : (w_is_last ? w_last_keep : 8'hFF);
  assign o_busy        = (r_state != S_IDLE);
  assign o_done        = r_done;
  assign o_frame_cnt   = r_frame_cnt;
endmodule

// File: doc/mac_axis_pkt_gen.md
MAC_AXIS_PKT_GEN -- requirements
Module: mac_axis_pkt_gen

Interface
REQ-001 Parameters SHALL be: DST_MAC, 48'hFFFF_FFFF_FFFF, destination address; SRC_MAC, 48'h0200_0000_0001, source address; ETHERTYPE, 16'h88B5, type field.
REQ-002 Widths SHALL use package constants N_SYMBOLS (8) and W_SYMBOL (8), giving a 64-bit beat.
REQ-003 i_clk  in  1  single clock; all logic is on the rising edge.
REQ-004 i_reset  in  1  asynchronous, active-high reset.
REQ-005 i_clk_en  in  1  qualifies every state, counter and handshake update.
REQ-006 i_start  in  1  one-cycle run request; honoured only in IDLE.
REQ-007 i_stop  in  1  request to end the run after the current frame.
REQ-008 i_len  in  16  frame length in bytes, excluding FCS; sampled at start.
REQ-009 i_n_frames  in  16  frames per run; 0 means continuous.
REQ-010 i_gap  in  8  idle i_clk_en cycles inserted between frames; sampled at start.
REQ-011 m_axis_tvalid  out  1  beat valid.
REQ-012 m_axis_tkeep  out  N_SYMBOLS  byte enables.
REQ-013 m_axis_tdata  out  N_SYMBOLS x W_SYMBOL  beat data; symbol 0 is the first byte on the wire.
REQ-014 m_axis_tlast  out  1  last beat of a frame.
REQ-015 m_axis_tready  in  1  downstream (MAC TX) ready.
REQ-016 o_busy  out  1  high in any state except IDLE.
REQ-017 o_done  out  1  one-cycle pulse when a run ends.
REQ-018 o_frame_cnt  out  32  frames completed since reset; wraps at 2^32.

Function
REQ-019 FSM states SHALL be IDLE, SEND and GAP; all transitions SHALL require i_clk_en=1.
REQ-020 IDLE→SEND on i_start; at that point L=clamp(i_len,60,1514), G=i_gap and N=i_n_frames are latched, and the sequence number seq is cleared.
REQ-021 A beat SHALL be accepted when i_clk_en & m_axis_tvalid & m_axis_tready are all high.
REQ-022 In SEND, m_axis_tvalid SHALL stay at 1 and tdata/tkeep/tlast SHALL stay stable until the beat is accepted.
REQ-023 A frame SHALL be ceil(L/8) beats; tlast is high only on the final beat.
REQ-024 On the final beat, tkeep SHALL have its low (L mod 8) bits set, or 8'hFF when L mod 8 = 0; all other beats SHALL have tkeep=8'hFF.
REQ-025 Frame byte layout:
- bytes 0-5 = DST_MAC, MSB first;
- bytes 6-11 = SRC_MAC, MSB first;
- bytes 12-13 = ETHERTYPE, MSB first;
- byte k, for k ≥ 14, = (k-14+seq) mod 256.
REQ-026 Bytes of the final beat that lie beyond L SHALL be driven to 0.
REQ-027 When the tlast beat is accepted: o_frame_cnt and seq SHALL increment.
REQ-028 After the tlast beat, if stop_pending, or N≠0 and the completed-frame count equals N, the FSM SHALL go to IDLE and pulse o_done.
REQ-029 Otherwise, after the tlast beat, the FSM SHALL go to GAP when G>0, or to SEND when G=0 (back-to-back, no idle beat).
REQ-030 GAP SHALL last exactly G i_clk_en-qualified cycles with tvalid=0, then go to SEND.
REQ-031 i_stop in SEND SHALL set stop_pending and the current frame SHALL complete.
REQ-032 i_stop in GAP SHALL return the FSM to IDLE on the next qualified cycle and pulse o_done.
REQ-033 i_stop in IDLE SHALL be ignored.
REQ-034 i_start outside IDLE SHALL be ignored; i_start and i_stop together in IDLE SHALL start nothing.
REQ-035 With i_clk_en=0: no state, counter or output register SHALL change, and tvalid SHALL hold its value.
REQ-036 The byte offset counter SHALL be 11 bits wide, the beat counter 8 bits and the gap counter 8 bits; none SHALL overflow for L ≤ 1514.

Reset
REQ-037 While i_reset=1, all outputs SHALL be 0, o_frame_cnt=0, the FSM SHALL be in IDLE and stop_pending SHALL be cleared.
REQ-038 Reset asserted mid-frame SHALL drop tvalid asynchronously; no partial frame SHALL resume after release.

Verification
REQ-039 L=60, N=1, G=0, tready=1 -> 8 beats; beat0 tdata bytes = FF×6, 02; beat7 tkeep=8'h0F with tlast; o_done follows 1 cycle after tlast; o_frame_cnt=1.
REQ-040 i_len=10 and i_len=2000 -> frames of 60 and 1514 bytes respectively; the 1514-byte frame is 190 beats with last tkeep=8'h03.
REQ-041 L=64, N=3, G=4 -> 3 frames of 8 beats each, 4-cycle tvalid=0 gaps between them, 8'hFF last tkeep; frame 2's byte 14 = 8'h02.
REQ-042 Random tready and random i_clk_en -> tdata/tkeep/tlast stable while tvalid=1 and tready=0; the accepted byte stream matches the reference model.
REQ-043 N=0 with i_stop pulsed mid-frame -> that frame completes with tlast, then IDLE plus o_done; a second i_stop pulse given during GAP -> IDLE with no further tvalid.
REQ-044 i_reset asserted at beat 3 -> tvalid=0 at once and o_frame_cnt=0; a new i_start then begins again at beat 0 with seq=0.
